input_port_arbiter: RTL
=======================

INPUT_PORT_ARBITER -- requirements
Module: input_port_arbiter

Interface
REQ-001 SHALL have parameter HOLD_TICKS, default 16'd4096, meaning the ce ticks of owner inactivity before ownership lapses.
REQ-002 SHALL have parameter GAP_TICKS, default 16'd16, meaning the ce ticks of released-port gap between owners.
REQ-003 SHALL have parameter PRIO_MOUSE, default 1'b1, meaning mouse wins simultaneous requests in IDLE.
REQ-004 SHALL have port clk, input, 1 bit: system clock.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port ce, input, 1: timer clock enable.
REQ-007 SHALL have port pad_act, input, 1: single-cycle joypad activity pulse.
REQ-008 SHALL have port pad_dir, input, 4: joypad {U,D,L,R}, active low.
REQ-009 SHALL have port pad_btn, input, 3: joypad buttons, active low.
REQ-010 SHALL have port mouse_act, input, 1: single-cycle mouse activity pulse (mouse packet strobe).
REQ-011 SHALL have port mouse_x, input, 2: X quadrature phase pair.
REQ-012 SHALL have port mouse_y, input, 2: Y quadrature phase pair.
REQ-013 SHALL have port mouse_btn, input, 3: {M,R,L} buttons, active low.
REQ-014 SHALL have port port_dir, output, 4: shared controller-port direction lines.
REQ-015 SHALL have port port_btn, output, 3: shared controller-port button lines.
REQ-016 SHALL have port owner, output, 2: 00 none, 01 pad, 10 mouse.
REQ-017 SHALL have port grant_pulse, output, 1: one-cycle high on every grant.

Function
REQ-018 SHALL implement the states IDLE, PAD, MOUSE and GAP.
REQ-019 In IDLE, on an activity pulse the block SHALL grant the requester on the next clk edge, load the hold timer with HOLD_TICKS, and assert grant_pulse; if both request, PRIO_MOUSE decides.
REQ-020 In PAD or MOUSE, owner activity SHALL reload the hold timer; the timer SHALL decrement by 1 per ce and saturate at 0.
REQ-021 When the hold timer is 0 and there is no owner activity that cycle, the block SHALL go to GAP with pending set, otherwise to IDLE; owner activity in the same cycle SHALL win and retain ownership.
REQ-022 In GAP, the gap counter SHALL load GAP_TICKS on entry and decrement per ce; at 0 the block SHALL grant the pending requester, load the hold timer, assert grant_pulse, and clear pending.
REQ-023 The outputs SHALL be registered with 1-clk latency from the inputs: PAD drives port_dir=pad_dir and port_btn=pad_btn; MOUSE drives port_dir={mouse_y,mouse_x} and port_btn=mouse_btn; IDLE and GAP drive all ones (released).
REQ-024 The owner output SHALL reflect the state registered in the same cycle as the output data; owner SHALL read 00 in IDLE and GAP.
REQ-025 A non-owner request during PAD, MOUSE or GAP SHALL NOT preempt the current owner.

Reset
REQ-026 Reset SHALL immediately force: state IDLE, port_dir=4'hF, port_btn=3'h7, owner=00, grant_pulse=0, timers=0, pending=0, including mid-GAP and mid-hold.

Configuration
REQ-027 With INPUT_ARB_PENDING_EN defined, a non-owner request during PAD, MOUSE or GAP SHALL set a sticky pending flag, which is served at hold expiry via GAP.
REQ-028 Without INPUT_ARB_PENDING_EN, such requests SHALL be dropped; hold expiry SHALL go to IDLE, and GAP is used only when a request arrives in the same cycle as expiry.

Structure
REQ-029 The shared package SHALL hold the state enum, the owner codes (NONE/PAD/MOUSE), and the default HOLD_TICKS and GAP_TICKS constants.
REQ-030 There SHALL be one sub-module, arb_tick_timer: a ce-driven 16-bit loadable down counter with saturation and a zero flag, instantiated for hold and for gap.

Verification
REQ-031 After a reset release, a pad_act pulse SHALL give owner=01 and grant_pulse one cycle later; pad_dir=4'b1110 SHALL appear on port_dir one cycle later.
REQ-032 With pad_act and mouse_act in the same cycle and PRIO_MOUSE=1, owner SHALL become 10 and port_dir SHALL equal {mouse_y,mouse_x}.
REQ-033 With the pad owner, HOLD_TICKS=8, ce always 1 and no activity, there SHALL be IDLE with owner=00 and outputs all ones after 8 ticks.
REQ-034 With INPUT_ARB_PENDING_EN, the pad owner, and a mouse_act mid-hold, the block SHALL go to GAP at expiry, hold ports all ones for GAP_TICKS=4 ce ticks, then grant mouse with grant_pulse.
REQ-035 Asserting reset during GAP SHALL immediately give owner=00 and outputs all ones, and pending SHALL be cleared, so there is no grant after release without a new request.
REQ-036 When owner activity coincides with hold timer=0, owner SHALL stay 01 and the timer SHALL reload to HOLD_TICKS.

Source files
------------

// File: rtl/input_port_arbiter_pkg.sv
// Shared types and constants for the controller-port arbiter: FSM states,
// owner codes, default timer loads and a small state-to-owner helper.
package input_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAD   = 2'd1,
        ST_MOUSE = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'b00,
        OWN_PAD   = 2'b01,
        OWN_MOUSE = 2'b10
    } owner_t;

    localparam logic [15:0] HOLD_TICKS_DEFAULT = 16'd4096;
    localparam logic [15:0] GAP_TICKS_DEFAULT  = 16'd16;

    localparam logic [3:0] DIR_RELEASED = 4'hF;
    localparam logic [2:0] BTN_RELEASED = 3'h7;

    // IDLE and GAP both leave the port released, so neither has an owner.
    function automatic owner_t ownerOf(input arb_state_t state);
        owner_t result;
        case (state)
            ST_PAD:   result = OWN_PAD;
            ST_MOUSE: result = OWN_MOUSE;
            default:  result = OWN_NONE;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/input_port_arbiter_timer.sv
// arb_tick_timer: ce-driven 16-bit loadable down counter that saturates at
// zero and flags it; used for both the hold and the gap timing.
module arb_tick_timer
    import input_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        i_load,
    input  logic [15:0] i_value,
    output logic        o_zero
);

    logic [15:0] r_count;

    // A load takes priority over a tick arriving in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 16'd0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (ce && (r_count != 16'd0)) begin
            r_count <= r_count - 16'd1;
        end
    end

    assign o_zero = (r_count == 16'd0);

endmodule

// File: rtl/input_port_arbiter.sv
// Arbitrates a joypad and a mouse onto one shared controller port.
// Optional feature macro: INPUT_ARB_PENDING_EN (sticky pending requests).
module input_port_arbiter
    import input_port_arbiter_pkg::*;
#(
    parameter logic [15:0] HOLD_TICKS = HOLD_TICKS_DEFAULT,
    parameter logic [15:0] GAP_TICKS  = GAP_TICKS_DEFAULT,
    parameter logic        PRIO_MOUSE = 1'b1
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       pad_act,
    input  logic [3:0] pad_dir,
    input  logic [2:0] pad_btn,
    input  logic       mouse_act,
    input  logic [1:0] mouse_x,
    input  logic [1:0] mouse_y,
    input  logic [2:0] mouse_btn,
    output logic [3:0] port_dir,
    output logic [2:0] port_btn,
    output logic [1:0] owner,
    output logic       grant_pulse
);

    arb_state_t r_state;
    arb_state_t w_nextState;
    logic       r_pending;
    logic       r_pendMouse;
    logic       w_nextPending;
    logic       w_nextPendMouse;
    logic       w_holdLoad;
    logic       w_gapLoad;
    logic       w_holdZero;
    logic       w_gapZero;
    logic       w_grant;
    logic       w_ownerAct;
    logic       w_otherAct;
    logic       w_otherIsMouse;
    logic       w_wantsTurn;

    logic [3:0] r_portDir;
    logic [2:0] r_portBtn;
    owner_t     r_owner;
    logic       r_grant;

    arb_tick_timer u_holdTimer (
        .clk     (clk),
        .reset   (reset),
        .ce      (ce),
        .i_load  (w_holdLoad),
        .i_value (HOLD_TICKS),
        .o_zero  (w_holdZero)
    );

    arb_tick_timer u_gapTimer (
        .clk     (clk),
        .reset   (reset),
        .ce      (ce),
        .i_load  (w_gapLoad),
        .i_value (GAP_TICKS),
        .o_zero  (w_gapZero)
    );

    // The pending target is always the port that does not currently own,
    // so a single bit records whether the mouse is the one waiting.
    always_comb begin
        w_nextState     = r_state;
        w_nextPending   = r_pending;
        w_nextPendMouse = r_pendMouse;
        w_holdLoad      = 1'b0;
        w_gapLoad       = 1'b0;
        w_grant         = 1'b0;
        w_ownerAct      = 1'b0;
        w_otherAct      = 1'b0;
        w_otherIsMouse  = 1'b0;
        w_wantsTurn     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (pad_act || mouse_act) begin
                    w_grant    = 1'b1;
                    w_holdLoad = 1'b1;
                    if (mouse_act && (PRIO_MOUSE || !pad_act)) begin
                        w_nextState = ST_MOUSE;
                    end else begin
                        w_nextState = ST_PAD;
                    end
                end
            end

            ST_PAD, ST_MOUSE: begin
                w_otherIsMouse = (r_state == ST_PAD);
                w_ownerAct     = w_otherIsMouse ? pad_act : mouse_act;
                w_otherAct     = w_otherIsMouse ? mouse_act : pad_act;
                w_wantsTurn    = r_pending || w_otherAct;
`ifdef INPUT_ARB_PENDING_EN
                if (w_otherAct) begin
                    w_nextPending   = 1'b1;
                    w_nextPendMouse = w_otherIsMouse;
                end
`endif
                // Owner activity beats expiry, even when the timer already reads zero.
                if (w_ownerAct) begin
                    w_holdLoad = 1'b1;
                end else if (w_holdZero) begin
                    if (w_wantsTurn) begin
                        w_nextState     = ST_GAP;
                        w_nextPending   = 1'b1;
                        w_nextPendMouse = w_otherIsMouse;
                        w_gapLoad       = 1'b1;
                    end else begin
                        w_nextState   = ST_IDLE;
                        w_nextPending = 1'b0;
                    end
                end
            end

            ST_GAP: begin
                if (w_gapZero) begin
                    w_grant       = 1'b1;
                    w_holdLoad    = 1'b1;
                    w_nextPending = 1'b0;
                    w_nextState   = r_pendMouse ? ST_MOUSE : ST_PAD;
                end
            end

            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Port data is registered from the next state so owner and data change together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pending   <= 1'b0;
            r_pendMouse <= 1'b0;
            r_portDir   <= DIR_RELEASED;
            r_portBtn   <= BTN_RELEASED;
            r_owner     <= OWN_NONE;
            r_grant     <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_pending   <= w_nextPending;
            r_pendMouse <= w_nextPendMouse;
            r_owner     <= ownerOf(w_nextState);
            r_grant     <= w_grant;
            case (w_nextState)
                ST_PAD: begin
                    r_portDir <= pad_dir;
                    r_portBtn <= pad_btn;
                end
                ST_MOUSE: begin
                    r_portDir <= {mouse_y, mouse_x};
                    r_portBtn <= mouse_btn;
                end
                default: begin
                    r_portDir <= DIR_RELEASED;
                    r_portBtn <= BTN_RELEASED;
                end
            endcase
        end
    end

    assign port_dir    = r_portDir;
    assign port_btn    = r_portBtn;
    assign owner       = r_owner;
    assign grant_pulse = r_grant;

endmodule
